// File: rtl/pe_gen_if.sv
// Array-facing bundle for one Generations PE: selects, command/data, neighbour
// status in; status, read-back and activity out.
interface pe_gen_if #(
  parameter int STATE_BITS = 4,
  parameter int AGE_BITS   = 8
);
  logic                  rsel_i, csel_i;
  logic                  rsel_o, csel_o;
  logic [2:0]            cmd;
  logic [STATE_BITS-1:0] state_in;
  logic [17:0]           rule_in;
  logic                  w_i, e_i, n_i, s_i, nw_i, ne_i, sw_i, se_i;
  logic                  status_out;
  logic [STATE_BITS-1:0] state_out;
  logic [STATE_BITS-1:0] state_out_prev;
  logic [AGE_BITS-1:0]   age_out;
  logic                  active;

  modport master (
    output rsel_i, csel_i, rsel_o, csel_o, cmd, state_in, rule_in,
           w_i, e_i, n_i, s_i, nw_i, ne_i, sw_i, se_i,
    input  status_out, state_out, state_out_prev, age_out, active
  );

  modport slave (
    input  rsel_i, csel_i, rsel_o, csel_o, cmd, state_in, rule_in,
           w_i, e_i, n_i, s_i, nw_i, ne_i, sw_i, se_i,
    output status_out, state_out, state_out_prev, age_out, active
  );
endinterface

// File: rtl/pe_gen.sv
// Generations-automaton processing element: loadable birth/survive masks,
// saturating age counter and one-level undo of the cell state.
module pe_gen #(
  parameter int         N_STATES     = 3,
  parameter int         STATE_BITS   = 4,
  parameter int         AGE_BITS     = 8,
  parameter logic [8:0] BIRTH_INIT   = 9'b000001000,
  parameter logic [8:0] SURVIVE_INIT = 9'b000001100
) (
  input  logic     clk,
  input  logic     rst,
  pe_gen_if.slave  bus
);

  localparam logic [2:0] CMD_PROCESS = 3'd1;
  localparam logic [2:0] CMD_WRITE   = 3'd2;
  localparam logic [2:0] CMD_CLEAR   = 3'd3;
  localparam logic [2:0] CMD_UNDO    = 3'd4;
  localparam logic [2:0] CMD_LOAD    = 3'd5;

  localparam logic [STATE_BITS-1:0] ST_DEAD  = '0;
  localparam logic [STATE_BITS-1:0] ST_LIVE  = STATE_BITS'(1);
  localparam logic [STATE_BITS-1:0] ST_LAST  = STATE_BITS'(N_STATES - 1);
  // With only two states a failing live cell dies outright instead of decaying.
  localparam logic [STATE_BITS-1:0] ST_DYING = (N_STATES == 2) ? ST_DEAD : STATE_BITS'(2);
  localparam logic [AGE_BITS-1:0]   AGE_MAX  = '1;

  logic [STATE_BITS-1:0] state_q, state_d;
  logic [STATE_BITS-1:0] prev_q, prev_d;
  logic [AGE_BITS-1:0]   age_q, age_d;
  logic [8:0]            birth_q, birth_d;
  logic [8:0]            survive_q, survive_d;
  logic                  active_q, active_d;

  logic [3:0]            nb_count;
  logic [STATE_BITS-1:0] proc_next;
  logic [STATE_BITS-1:0] wr_val;
  logic                  sel_wr, sel_rd;

  assign sel_wr = bus.rsel_i & bus.csel_i;
  assign sel_rd = bus.rsel_o & bus.csel_o;

  assign nb_count = {3'b0, bus.w_i}  + {3'b0, bus.e_i}  + {3'b0, bus.n_i}  + {3'b0, bus.s_i}
                  + {3'b0, bus.nw_i} + {3'b0, bus.ne_i} + {3'b0, bus.sw_i} + {3'b0, bus.se_i};

  // Out-of-range write data is stored as dead so the state never leaves 0..N_STATES-1.
  assign wr_val = (32'(bus.state_in) >= N_STATES) ? ST_DEAD : bus.state_in;

  always_comb begin
    proc_next = ST_DEAD;
    if (state_q == ST_DEAD) begin
      proc_next = birth_q[nb_count] ? ST_LIVE : ST_DEAD;
    end else if (state_q == ST_LIVE) begin
      proc_next = survive_q[nb_count] ? ST_LIVE : ST_DYING;
    end else if (state_q < ST_LAST) begin
      proc_next = state_q + STATE_BITS'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    age_d     = age_q;
    birth_d   = birth_q;
    survive_d = survive_q;
    case (bus.cmd)
      CMD_PROCESS: begin
        state_d = proc_next;
        prev_d  = state_q;
        if (state_q == ST_LIVE && proc_next == ST_LIVE)
          age_d = (age_q == AGE_MAX) ? age_q : age_q + AGE_BITS'(1);
        else
          age_d = '0;
      end
      CMD_WRITE: if (sel_wr) begin
        state_d = wr_val;
        prev_d  = wr_val;
        age_d   = '0;
      end
      CMD_CLEAR: if (sel_wr) begin
        state_d = ST_DEAD;
        prev_d  = ST_DEAD;
        age_d   = '0;
      end
      CMD_UNDO: begin
        state_d = prev_q;
        age_d   = '0;
      end
      CMD_LOAD: if (sel_wr) begin
        birth_d   = bus.rule_in[17:9];
        survive_d = bus.rule_in[8:0];
      end
      default: ;
    endcase
    active_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= '0;
      prev_q    <= '0;
      age_q     <= '0;
      birth_q   <= BIRTH_INIT;
      survive_q <= SURVIVE_INIT;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      age_q     <= age_d;
      birth_q   <= birth_d;
      survive_q <= survive_d;
      active_q  <= active_d;
    end
  end

  assign bus.status_out     = (state_q == ST_LIVE);
  assign bus.state_out      = sel_rd ? state_q : '0;
  assign bus.state_out_prev = sel_rd ? prev_q  : '0;
  assign bus.age_out        = sel_rd ? age_q   : '0;
  assign bus.active         = active_q;

endmodule

// File: tb/tb_pe_gen.sv
// Directed bench for pe_gen (N_STATES=3, AGE_BITS=8): hand-computed expectations
// checked with immediate assertions one cycle after each command edge.
module tb_pe_gen;
  localparam logic [2:0] NOP = 3'd0, PROC = 3'd1, WR = 3'd2, CLR = 3'd3,
                         UNDO = 3'd4, LOAD = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  pe_gen_if #(.STATE_BITS(4), .AGE_BITS(8)) bus ();

  pe_gen #(
    .N_STATES(3), .STATE_BITS(4), .AGE_BITS(8),
    .BIRTH_INIT(9'b000001000), .SURVIVE_INIT(9'b000001100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_nb(input int n);
    logic [7:0] v;
    v = 8'((1 << n) - 1);
    {bus.se_i, bus.sw_i, bus.ne_i, bus.nw_i, bus.s_i, bus.n_i, bus.e_i, bus.w_i} = v;
  endtask

  task automatic step(input logic [2:0] c);
    bus.cmd = c;
    @(posedge clk);
    #1;
    bus.cmd = NOP;
  endtask

  task automatic chk_cell(input string tag, input int st, input int pv, input int age, input int act);
    chk({tag, ".state"},  32'(bus.state_out), 32'(st));
    chk({tag, ".prev"},   32'(bus.state_out_prev), 32'(pv));
    chk({tag, ".age"},    32'(bus.age_out), 32'(age));
    chk({tag, ".active"}, 32'(bus.active), 32'(act));
    chk({tag, ".status"}, 32'(bus.status_out), (st == 1) ? 32'd1 : 32'd0);
  endtask

  initial begin
    bus.cmd = NOP; bus.state_in = '0; bus.rule_in = '0;
    bus.rsel_i = 1'b1; bus.csel_i = 1'b1; bus.rsel_o = 1'b1; bus.csel_o = 1'b1;
    set_nb(0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_cell("reset", 0, 0, 0, 0);

    // Birth on three neighbours under B3/S23.
    set_nb(3);
    step(PROC);
    chk_cell("birth3", 1, 0, 0, 1);

    // Survival on two neighbours; age climbs and saturates.
    set_nb(2);
    repeat (254) step(PROC);
    chk_cell("age254", 1, 1, 254, 0);
    step(PROC);
    chk("age255", 32'(bus.age_out), 32'd255);
    repeat (45) step(PROC);
    chk_cell("age_sat", 1, 1, 255, 0);

    // Read select gates the read-back ports but not status_out.
    bus.rsel_o = 1'b0;
    #1;
    chk("gate.state", 32'(bus.state_out), 32'd0);
    chk("gate.age", 32'(bus.age_out), 32'd0);
    chk("gate.status", 32'(bus.status_out), 32'd1);
    bus.rsel_o = 1'b1;

    // Overcrowding: live -> dying -> dead, dying ignores neighbours.
    set_nb(4);
    step(PROC);
    chk_cell("die4", 2, 1, 0, 1);
    set_nb(3);
    step(PROC);
    chk_cell("dying_end", 0, 2, 0, 1);

    // Default rule: six neighbours do not give birth.
    set_nb(6);
    step(PROC);
    chk_cell("b6_default", 0, 0, 0, 0);

    // Load B36/S23; state untouched, next PROCESS uses the new rule.
    bus.rule_in = {9'b001001000, 9'b000001100};
    step(LOAD);
    chk_cell("load", 0, 0, 0, 0);
    step(PROC);
    chk_cell("b6_loaded", 1, 0, 0, 1);

    // Write clamps out-of-range data; unselected write holds.
    bus.state_in = 4'd5;
    step(WR);
    chk_cell("wr5_clamp", 0, 0, 0, 1);
    bus.state_in = 4'd2; bus.rsel_i = 1'b0;
    step(WR);
    chk_cell("wr_unsel", 0, 0, 0, 0);
    bus.rsel_i = 1'b1;
    step(WR);
    chk_cell("wr2", 2, 2, 0, 1);

    // Undo: live -> dying, undo restores live, second undo is a no-op.
    bus.state_in = 4'd1;
    step(WR);
    chk_cell("wr1", 1, 1, 0, 1);
    set_nb(1);
    step(PROC);
    chk_cell("die1", 2, 1, 0, 1);
    step(UNDO);
    chk_cell("undo1", 1, 1, 0, 1);
    step(UNDO);
    chk_cell("undo2", 1, 1, 0, 0);

    // Reserved command behaves as NOP.
    step(3'd6);
    chk_cell("cmd6", 1, 1, 0, 0);

    // Clear.
    step(CLR);
    chk_cell("clear", 0, 0, 0, 1);

    // Build a nonzero cell with an aged history, then reset during a WRITE.
    bus.state_in = 4'd1;
    step(WR);
    set_nb(2);
    step(PROC);
    chk_cell("pre_rst", 1, 1, 1, 0);
    bus.state_in = 4'd2; bus.cmd = WR; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; bus.cmd = NOP;
    chk_cell("rst_wr", 0, 0, 0, 0);
    bus.csel_o = 1'b0;
    #1;
    chk("rst_gate", 32'(bus.state_out), 32'd0);
    bus.csel_o = 1'b1;

    // Masks restored to B3/S23.
    set_nb(6);
    step(PROC);
    chk_cell("rst_b6", 0, 0, 0, 0);
    set_nb(3);
    step(PROC);
    chk_cell("rst_b3", 1, 0, 0, 1);
    step(PROC);
    chk_cell("rst_s3", 1, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
